// File: rtl/irq_controller.sv
// Interrupt front-end for the multicycle MIPS core: N maskable edge/level channels
// with fixed lowest-index priority, plus an NMI that can pre-empt one maskable handler.
module irq_controller #(
  parameter int                 NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE = {NUM_IRQ{1'b1}},
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  VEC_BASE  = 32'h0000_0100,
  parameter logic [ADDR_W-1:0]  NMI_VEC   = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi,
  input  logic               en_we,
  input  logic [NUM_IRQ-1:0] en_wdata,
  input  logic               ina,
  input  logic               eoi,
  output logic               int_req,
  output logic               int_is_nmi,
  output logic [4:0]         int_id,
  output logic [ADDR_W-1:0]  int_vector,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE,
    ST_NMI_REQ,
    ST_NMI_SERVICE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_IRQ-1:0]  irq_q, en_q, epend_q, epend_d;
  logic                nmi_q, nmi_pend_q, nmi_pend_d;
  logic                nested_q, nested_d;
  logic [4:0]          id_q, id_d;
  logic [ADDR_W-1:0]   vec_q, vec_d;

  logic [NUM_IRQ-1:0]  sel, id_onehot, ack_mask;
  logic                any_sel, cur_sel, ack_edge, ack_nmi;
  logic [4:0]          win_id;

  function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [ADDR_W-1:0] chan_vec(input logic [4:0] id);
    return VEC_BASE + (ADDR_W'(id) << 2);
  endfunction

  // Level channels follow the registered line; edge channels use the sticky latch.
  assign pending   = (epend_q & EDGE_MODE) | (irq_q & ~EDGE_MODE);
  assign sel       = pending & en_q;
  assign any_sel   = |sel;
  assign win_id    = lowest_idx(sel);
  assign id_onehot = NUM_IRQ'(1) << id_q;
  assign cur_sel   = |(sel & id_onehot);
  assign ack_mask  = ack_edge ? id_onehot : '0;

  assign epend_d    = (epend_q & ~ack_mask) | (irq & ~irq_q);
  assign nmi_pend_d = (nmi_pend_q & ~ack_nmi) | (nmi & ~nmi_q);

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vec_d    = vec_q;
    nested_d = nested_q;
    ack_edge = 1'b0;
    ack_nmi  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nmi_pend_q) begin
          state_d = ST_NMI_REQ;
        end else if (any_sel) begin
          state_d = ST_REQ;
          id_d    = win_id;
          vec_d   = chan_vec(win_id);
        end
      end
      ST_REQ: begin
        if (nmi_pend_q) begin
          state_d = ST_NMI_REQ;
        end else if (ina) begin
          state_d  = ST_SERVICE;
          ack_edge = 1'b1;
        end else if (!cur_sel) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        // id_q/vec_q are left untouched during the NMI so they serve as the saved context.
        if (eoi) begin
          state_d = ST_IDLE;
        end else if (nmi_pend_q) begin
          state_d  = ST_NMI_REQ;
          nested_d = 1'b1;
        end
      end
      ST_NMI_REQ: begin
        if (ina) begin
          state_d = ST_NMI_SERVICE;
          ack_nmi = 1'b1;
        end
      end
      ST_NMI_SERVICE: begin
        if (eoi) begin
          state_d  = nested_q ? ST_SERVICE : ST_IDLE;
          nested_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      irq_q      <= '0;
      nmi_q      <= 1'b0;
      en_q       <= '0;
      epend_q    <= '0;
      nmi_pend_q <= 1'b0;
      nested_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq;
      nmi_q      <= nmi;
      en_q       <= en_we ? en_wdata : en_q;
      epend_q    <= epend_d;
      nmi_pend_q <= nmi_pend_d;
      nested_q   <= nested_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q  <= id_d;
    vec_q <= vec_d;
  end

  assign int_req    = (state_q == ST_REQ) || (state_q == ST_NMI_REQ);
  assign int_is_nmi = (state_q == ST_NMI_REQ) || (state_q == ST_NMI_SERVICE);
  assign in_service = (state_q == ST_SERVICE) || (state_q == ST_NMI_SERVICE);
  assign int_id     = ((state_q == ST_REQ) || (state_q == ST_SERVICE)) ? id_q : '0;
  assign int_vector = int_is_nmi ? NMI_VEC :
                      ((state_q == ST_REQ) || (state_q == ST_SERVICE)) ? vec_q : '0;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a request/handler-stack model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_irq_controller;

  localparam int         N       = 8;
  localparam logic [7:0] EDGE    = 8'hBF;
  localparam int         NMI_TOK = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        nmi, en_we, ina, eoi;
  logic [7:0]  en_wdata;
  logic        int_req, int_is_nmi, in_service;
  logic [4:0]  int_id;
  logic [31:0] int_vector;
  logic [7:0]  pending;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  irq_controller #(
    .NUM_IRQ  (N),
    .EDGE_MODE(EDGE),
    .ADDR_W   (32),
    .VEC_BASE (32'h0000_0100),
    .NMI_VEC  (32'h0000_0080)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .nmi       (nmi),
    .en_we     (en_we),
    .en_wdata  (en_wdata),
    .ina       (ina),
    .eoi       (eoi),
    .int_req   (int_req),
    .int_is_nmi(int_is_nmi),
    .int_id    (int_id),
    .int_vector(int_vector),
    .in_service(in_service),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Model: one outstanding request token plus a stack of active handlers.
  logic [7:0] m_epend = '0;
  logic [7:0] m_irq_prev = '0;
  logic [7:0] m_en = '0;
  bit         m_nmi_pend = 1'b0;
  bit         m_nmi_prev = 1'b0;
  int         m_req = -1;
  int         stk[$];

  function automatic logic [7:0] m_pending();
    return (m_epend & EDGE) | (m_irq_prev & ~EDGE);
  endfunction

  function automatic int m_lowest();
    logic [7:0] s;
    s = m_pending() & m_en;
    for (int i = 0; i < N; i++) if (s[i]) return i;
    return -1;
  endfunction

  initial forever begin
    logic [7:0] clr, s;
    bit nclr;
    int low;
    @(posedge clk);
    clr = '0;
    nclr = 1'b0;
    if (reset) begin
      m_epend = '0; m_irq_prev = '0; m_en = '0;
      m_nmi_pend = 1'b0; m_nmi_prev = 1'b0;
      m_req = -1;
      stk.delete();
    end else begin
      low = m_lowest();
      s = m_pending() & m_en;
      if (m_req >= 0) begin
        if (m_nmi_pend && m_req != NMI_TOK) m_req = NMI_TOK;
        else if (ina) begin
          stk.push_back(m_req);
          if (m_req == NMI_TOK) nclr = 1'b1;
          else clr[m_req] = 1'b1;
          m_req = -1;
        end else if (m_req != NMI_TOK && !s[m_req]) m_req = -1;
      end else if (stk.size() > 0) begin
        if (eoi) void'(stk.pop_back());
        else if (stk[$] != NMI_TOK && m_nmi_pend) m_req = NMI_TOK;
      end else begin
        if (m_nmi_pend) m_req = NMI_TOK;
        else if (low >= 0) m_req = low;
      end
      m_epend    = (m_epend & ~clr) | (irq & ~m_irq_prev);
      m_nmi_pend = (m_nmi_pend & !nclr) | (nmi & !m_nmi_prev);
      if (en_we) m_en = en_wdata;
      m_irq_prev = irq;
      m_nmi_prev = nmi;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    int tok;
    @(negedge clk);
    if (chk_en) begin
      tok = (m_req >= 0) ? m_req : ((stk.size() > 0) ? stk[$] : -1);
      chk("m_int_req", 32'(int_req), 32'(m_req >= 0));
      chk("m_int_is_nmi", 32'(int_is_nmi), 32'(tok == NMI_TOK));
      chk("m_in_service", 32'(in_service), 32'(m_req < 0 && stk.size() > 0));
      chk("m_int_id", 32'(int_id), (tok >= 0 && tok != NMI_TOK) ? 32'(tok) : 32'd0);
      chk("m_int_vector", int_vector,
          (tok == NMI_TOK) ? 32'h80 : (tok >= 0) ? 32'h100 + 32'(4 * tok) : 32'd0);
      chk("m_pending", 32'(pending), 32'(m_pending()));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ina();
    ina = 1'b1; step(); ina = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  task automatic write_en(input logic [7:0] v);
    en_we = 1'b1; en_wdata = v; step(); en_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; nmi = 1'b0; en_we = 1'b0; en_wdata = '0;
    ina = 1'b0; eoi = 1'b0;
    step(2);
    reset = 1'b0;
    chk_en = 1'b1;
    step();
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_int_vector", int_vector, 32'd0);

    // Single edge channel 3
    write_en(8'hFF);
    irq = 8'h08; step(); irq = '0;
    chk("t1_pending_set", 32'(pending), 32'h08);
    chk("t1_no_req_yet", 32'(int_req), 32'd0);
    step();
    chk("t1_int_req", 32'(int_req), 32'd1);
    chk("t1_int_id", 32'(int_id), 32'd3);
    chk("t1_int_vector", int_vector, 32'h10C);
    pulse_ina();
    chk("t1_pend_clr", 32'(pending), 32'h00);
    chk("t1_in_service", 32'(in_service), 32'd1);
    chk("t1_req_drop", 32'(int_req), 32'd0);
    pulse_eoi();
    chk("t1_idle", 32'(in_service), 32'd0);

    // Priority: channels 5 and 2 together
    irq = 8'h24; step(); irq = '0; step();
    chk("t2_first_id", 32'(int_id), 32'd2);
    pulse_ina(); pulse_eoi(); step();
    chk("t2_second_id", 32'(int_id), 32'd5);
    chk("t2_second_vec", int_vector, 32'h114);
    pulse_ina(); pulse_eoi();

    // Masked channel still latches
    write_en(8'h00);
    irq = 8'h02; step(); irq = '0; step();
    chk("t3_pend_masked", 32'(pending), 32'h02);
    chk("t3_no_req", 32'(int_req), 32'd0);
    write_en(8'h02);
    step();
    chk("t3_req", 32'(int_req), 32'd1);
    chk("t3_id", 32'(int_id), 32'd1);
    pulse_ina(); pulse_eoi();
    write_en(8'hFF);

    // Nested NMI over channel 4
    irq = 8'h10; step(); irq = '0; step();
    pulse_ina();
    chk("t4_svc_id", 32'(int_id), 32'd4);
    nmi = 1'b1; step(); nmi = 1'b0; step();
    chk("t4_is_nmi", 32'(int_is_nmi), 32'd1);
    chk("t4_nmi_vec", int_vector, 32'h80);
    chk("t4_nmi_req", 32'(int_req), 32'd1);
    pulse_ina();
    chk("t4_nmi_svc", 32'(in_service), 32'd1);
    pulse_eoi();
    chk("t4_restored_id", 32'(int_id), 32'd4);
    chk("t4_restored_vec", int_vector, 32'h110);
    chk("t4_restored_svc", 32'(in_service), 32'd1);
    chk("t4_restored_nmi", 32'(int_is_nmi), 32'd0);
    pulse_eoi();
    chk("t4_idle", 32'(in_service), 32'd0);

    // Level channel 6
    irq = 8'h40; step(2);
    chk("t5_id", 32'(int_id), 32'd6);
    pulse_ina();
    chk("t5_level_pend", 32'(pending), 32'h40);
    pulse_eoi();
    chk("t5_idle_req", 32'(int_req), 32'd0);
    step();
    chk("t5_rereq", 32'(int_req), 32'd1);
    chk("t5_rereq_id", 32'(int_id), 32'd6);
    irq = '0; step(2);
    chk("t5_drop_req", 32'(int_req), 32'd0);
    chk("t5_drop_svc", 32'(in_service), 32'd0);

    // Reset during nested NMI service
    irq = 8'h01; step(); irq = '0; step();
    pulse_ina();
    nmi = 1'b1; step(); nmi = 1'b0; step();
    pulse_ina();
    chk("t6_nmi_svc", 32'(int_is_nmi), 32'd1);
    irq = 8'h08; step(); irq = '0;
    chk("t6_pend_before", 32'(pending), 32'h08);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_rst_req", 32'(int_req), 32'd0);
    chk("t6_rst_nmi", 32'(int_is_nmi), 32'd0);
    chk("t6_rst_id", 32'(int_id), 32'd0);
    chk("t6_rst_vec", int_vector, 32'd0);
    chk("t6_rst_svc", 32'(in_service), 32'd0);
    chk("t6_rst_pend", 32'(pending), 32'd0);
    ina = 1'b1; eoi = 1'b1; step(); ina = 1'b0; eoi = 1'b0;
    chk("t6_after_req", 32'(int_req), 32'd0);
    chk("t6_after_svc", 32'(in_service), 32'd0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
